// File: rtl/rx78_cart_loader.sv
// rx78_cart_loader: turns the ioctl cartridge download stream into the RX-78
// upload bus, pads the image with 0xFF up to a cart-size boundary, holds the
// Z80 in reset for the load plus a tail, and reports the detected cart size.
module rx78_cart_loader #(
  parameter logic [7:0]  CART_INDEX  = 8'd1,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned RESET_TAIL  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        upload,
  output logic [7:0]  upload_index,
  output logic [24:0] upload_addr,
  output logic [7:0]  upload_data,
  output logic        cpu_reset,
  output logic [1:0]  cart_size,
  output logic        overrun,
  output logic        truncated
);

  localparam int unsigned AW = 25;
  localparam int unsigned MW = 15;  // accepted byte address width
  localparam int unsigned PW = 16;  // pad counter with one spare bit so it never wraps
  localparam int unsigned HW = 4;
  localparam int unsigned TW = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  localparam logic [AW-1:0] ADDR_LIMIT = 25'h8000;
  localparam logic [MW-1:0] END_8K     = 15'h1FFF;
  localparam logic [MW-1:0] END_16K    = 15'h3FFF;
  localparam logic [MW-1:0] END_32K    = 15'h7FFF;

  logic [1:0]    state,    state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [HW-1:0] pad_div,  pad_div_n;
  logic [TW-1:0] tail_cnt, tail_n;
  logic [MW-1:0] max_addr, max_n;
  logic          any_byte, any_n;
  logic [PW-1:0] pad_addr, pad_addr_n;
  logic [MW-1:0] pad_end,  pad_end_n;
  logic          dl_q;

  logic          ioctl_wait_n, upload_n, cpu_reset_n, overrun_n, truncated_n;
  logic [7:0]    upload_index_n, upload_data_n;
  logic [AW-1:0] upload_addr_n;
  logic [1:0]    cart_size_n;
  logic          start_hit, start_rise, enter_load;

  // Next-state and next-output logic for the loader sequence
  always_comb begin
    state_n        = state;
    hold_n         = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
    pad_div_n      = pad_div;
    tail_n         = tail_cnt;
    max_n          = max_addr;
    any_n          = any_byte;
    pad_addr_n     = pad_addr;
    pad_end_n      = pad_end;
    upload_n       = upload;
    upload_index_n = upload_index;
    upload_addr_n  = upload_addr;
    upload_data_n  = upload_data;
    cpu_reset_n    = cpu_reset;
    cart_size_n    = cart_size;
    overrun_n      = overrun;
    truncated_n    = truncated;
    enter_load     = 1'b0;

    start_hit  = ioctl_download && (ioctl_index == CART_INDEX);
    start_rise = start_hit && !dl_q;

    case (state)
      S_IDLE: begin
        if (start_hit) enter_load = 1'b1;
      end

      S_LOAD: begin
        if (ioctl_wr) begin
          if (hold_cnt != '0) begin
            overrun_n = 1'b1;
          end else if (ioctl_addr >= ADDR_LIMIT) begin
            truncated_n = 1'b1;
          end else begin
            upload_addr_n = ioctl_addr;
            upload_data_n = ioctl_dout;
            hold_n        = HW'(HOLD_CYCLES);
            any_n         = 1'b1;
            if (MW'(ioctl_addr) > max_addr) max_n = MW'(ioctl_addr);
          end
        end else if (!ioctl_download && (hold_cnt == '0)) begin
          // Download closed and last byte fully held: choose the pad window
          state_n    = S_PAD;
          pad_div_n  = '0;
          pad_addr_n = any_byte ? (PW'(max_addr) + PW'(1)) : '0;
          if (!any_byte || (max_addr < 15'h2000)) pad_end_n = END_8K;
          else if (max_addr < 15'h4000)          pad_end_n = END_16K;
          else                                    pad_end_n = END_32K;
        end
      end

      S_PAD: begin
        if (start_rise) begin
          enter_load = 1'b1;
        end else if (pad_div != '0) begin
          pad_div_n = pad_div - HW'(1);
        end else if (pad_addr > PW'(pad_end)) begin
          state_n        = S_TAIL;
          upload_n       = 1'b0;
          upload_index_n = '0;
          tail_n         = TW'(RESET_TAIL);
          if (!any_byte)               cart_size_n = 2'd0;
          else if (pad_end == END_8K)  cart_size_n = 2'd1;
          else if (pad_end == END_16K) cart_size_n = 2'd2;
          else                         cart_size_n = 2'd3;
        end else begin
          upload_addr_n = AW'(pad_addr);
          upload_data_n = 8'hFF;
          pad_div_n     = HW'(HOLD_CYCLES - 1);
          pad_addr_n    = pad_addr + PW'(1);
        end
      end

      S_TAIL: begin
        if (start_rise) begin
          enter_load = 1'b1;
        end else if (tail_cnt <= TW'(1)) begin
          state_n     = S_IDLE;
          cpu_reset_n = 1'b0;
        end else begin
          tail_n = tail_cnt - TW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (enter_load) begin
      state_n        = S_LOAD;
      max_n          = '0;
      any_n          = 1'b0;
      overrun_n      = 1'b0;
      truncated_n    = 1'b0;
      cpu_reset_n    = 1'b1;
      upload_n       = 1'b1;
      upload_index_n = CART_INDEX;
      hold_n         = '0;
    end

    ioctl_wait_n = (hold_n != '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      pad_div      <= '0;
      tail_cnt     <= '0;
      max_addr     <= '0;
      any_byte     <= 1'b0;
      pad_addr     <= '0;
      pad_end      <= '0;
      dl_q         <= 1'b0;
      ioctl_wait   <= 1'b0;
      upload       <= 1'b0;
      upload_index <= '0;
      upload_addr  <= '0;
      upload_data  <= '0;
      cpu_reset    <= 1'b0;
      cart_size    <= '0;
      overrun      <= 1'b0;
      truncated    <= 1'b0;
    end else begin
      state        <= state_n;
      hold_cnt     <= hold_n;
      pad_div      <= pad_div_n;
      tail_cnt     <= tail_n;
      max_addr     <= max_n;
      any_byte     <= any_n;
      pad_addr     <= pad_addr_n;
      pad_end      <= pad_end_n;
      dl_q         <= ioctl_download;
      ioctl_wait   <= ioctl_wait_n;
      upload       <= upload_n;
      upload_index <= upload_index_n;
      upload_addr  <= upload_addr_n;
      upload_data  <= upload_data_n;
      cpu_reset    <= cpu_reset_n;
      cart_size    <= cart_size_n;
      overrun      <= overrun_n;
      truncated    <= truncated_n;
    end
  end

endmodule
